// File: rtl/uart_tx_arb.sv
// Four-port byte arbiter feeding a single uart_tx.
// Round-robin lock per message, released on last byte or idle timeout.
module uart_tx_arb #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    input  logic [3:0]  last,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic        tx_req,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_e;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [3:0]  grant_q;
    logic [1:0]  owner_q;
    logic [1:0]  ptr_q;
    logic [15:0] cnt_q;

    logic [7:0]  req2;
    logic [3:0]  rot;
    logic [1:0]  off;
    logic [1:0]  pick;
    logic        accept;

    // Rotate requests so bit 0 is the port under the pointer.
    assign req2 = {req, req};
    assign rot  = req2[{1'b0, ptr_q} +: 4];

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign pick    = ptr_q + off;
    assign tx_req  = (state_q == LOCK) && req[owner_q];
    assign tx_data = (state_q == LOCK) ? data[{owner_q, 3'b000} +: 8] : 8'h00;
    assign accept  = tx_req && tx_ready;
    assign ack     = {4{accept}} & grant_q;
    assign grant   = grant_q;
    assign busy    = |grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= LOCK;
                        owner_q <= pick;
                        grant_q <= 4'b0001 << pick;
                        cnt_q   <= 16'd0;
                    end
                end
                LOCK: begin
                    if (accept && last[owner_q]) begin
                        state_q <= IDLE;
                        grant_q <= 4'b0000;
                        ptr_q   <= owner_q + 2'd1;
                        cnt_q   <= 16'd0;
                    end else if (req[owner_q]) begin
                        cnt_q <= 16'd0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        grant_q <= 4'b0000;
                        ptr_q   <= owner_q + 2'd1;
                        cnt_q   <= 16'd0;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: vector table, directed sequences,
// and random traffic against a message-level reference model.
module tb_uart_tx_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_req;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        busy;

    int tests = 0;
    int failed = 0;

    // Reference model: owner index (-1 = none), next-priority port, low-cycle count.
    int own;
    int ptr;
    int low;
    logic [3:0] m_ack;

    uart_tx_arb #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .last     (last),
        .ack      (ack),
        .grant    (grant),
        .tx_req   (tx_req),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input logic [3:0] l,
                       input logic [31:0] d, input logic rdy);
        logic [3:0] eg;
        logic       etr;
        logic [7:0] etd;
        @(negedge clk);
        reset = r; req = q; last = l; data = d; tx_ready = rdy;
        #1;
        eg    = (own < 0) ? 4'b0000 : 4'(1 << own);
        etr   = (own >= 0) && q[own];
        etd   = (own >= 0) ? d[8*own +: 8] : 8'h00;
        m_ack = (etr && rdy) ? eg : 4'b0000;
        chk("grant",   32'(grant),   32'(eg));
        chk("tx_req",  32'(tx_req),  32'(etr));
        chk("tx_data", 32'(tx_data), 32'(etd));
        chk("ack",     32'(ack),     32'(m_ack));
        chk("busy",    32'(busy),    32'(own >= 0));
        if (r) begin
            own = -1; ptr = 0; low = 0;
        end else if (own < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (own < 0 && q[(ptr + k) % 4]) begin
                    own = (ptr + k) % 4;
                    low = 0;
                end
            end
        end else if (m_ack != 0 && l[own]) begin
            ptr = (own + 1) % 4;
            own = -1;
        end else if (q[own]) begin
            low = 0;
        end else begin
            low++;
            if (low == TO) begin
                ptr = (own + 1) % 4;
                own = -1;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  g;
        logic [3:0]  a;
        logic        tr;
        logic [7:0]  td;
    } vec_t;

    vec_t tbl[15];

    logic       act[4];
    logic [7:0] byt[4];
    logic       lst[4];
    int rr[10] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'h4, 4'h0, 32'h0041_0000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h4, 4'h0, 32'h0041_0000, 1'b0, 4'h4, 4'h0, 1'b1, 8'h41};
        tbl[3]  = '{1'b0, 4'h4, 4'h0, 32'h0041_0000, 1'b1, 4'h4, 4'h4, 1'b1, 8'h41};
        tbl[4]  = '{1'b0, 4'h4, 4'h0, 32'h0042_0000, 1'b0, 4'h4, 4'h0, 1'b1, 8'h42};
        tbl[5]  = '{1'b0, 4'h4, 4'h0, 32'h0042_0000, 1'b1, 4'h4, 4'h4, 1'b1, 8'h42};
        tbl[6]  = '{1'b0, 4'h4, 4'h4, 32'h0043_0000, 1'b1, 4'h4, 4'h4, 1'b1, 8'h43};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0055, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0055, 1'b0, 4'h1, 4'h0, 1'b1, 8'h55};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 32'h0000_0055, 1'b1, 4'h1, 4'h0, 1'b0, 8'h55};
        tbl[11] = '{1'b0, 4'h1, 4'h0, 32'h0000_0055, 1'b0, 4'h1, 4'h0, 1'b1, 8'h55};
        tbl[12] = '{1'b1, 4'h1, 4'h0, 32'h0000_0055, 1'b0, 4'h1, 4'h0, 1'b1, 8'h55};
        tbl[13] = '{1'b0, 4'hC, 4'h0, 32'h8877_0000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 4'hC, 4'h0, 32'h8877_0000, 1'b0, 4'h4, 4'h0, 1'b1, 8'h77};

        reset = 1'b1; req = 4'h0; last = 4'h0; data = 32'h0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        own = -1; ptr = 0; low = 0; m_ack = 4'h0;

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].data, tbl[i].rdy);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].a));
            chk($sformatf("tbl%0d_txreq", i), 32'(tx_req), 32'(tbl[i].tr));
            chk($sformatf("tbl%0d_txdata", i), 32'(tx_data), 32'(tbl[i].td));
        end

        // Round robin, one-byte messages, all ports requesting.
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 4'hF, 4'hF, 32'h4433_2211, 1'b1);
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(rr[k]));
        end

        // No preemption of a message in progress.
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AA, 1'b0);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AA, 1'b1);
        chk("pre_ack1", 32'(ack), 32'h1);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AB, 1'b0);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AB, 1'b1);
        chk("pre_grant2", 32'(grant), 32'h1);
        cyc(1'b0, 4'h9, 4'h1, 32'hDD00_00AC, 1'b1);
        chk("pre_ack3", 32'(ack), 32'h1);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AD, 1'b0);
        chk("pre_idle", 32'(grant), 32'h0);
        cyc(1'b0, 4'h9, 4'h0, 32'hDD00_00AD, 1'b0);
        chk("pre_next", 32'(grant), 32'h8);
        chk("pre_data", 32'(tx_data), 32'hDD);

        // Owner timeout with a re-assert that restarts the count.
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        cyc(1'b0, 4'h2, 4'h0, 32'h0000_1100, 1'b0);
        cyc(1'b0, 4'h2, 4'h0, 32'h0000_1100, 1'b0);
        chk("to_grant", 32'(grant), 32'h2);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'h0, 4'h0, 32'h0000_1100, 1'b1);
            chk("to_low_ack", 32'(ack), 32'h0);
        end
        cyc(1'b0, 4'h2, 4'h0, 32'h0000_1100, 1'b0);
        chk("to_reassert", 32'(grant), 32'h2);
        for (int k = 0; k < TO; k++) begin
            cyc(1'b0, 4'h0, 4'h0, 32'h0000_1100, 1'b1);
            chk("to_held", 32'(grant), 32'h2);
            chk("to_noack", 32'(ack), 32'h0);
        end
        cyc(1'b0, 4'h0, 4'h0, 32'h0000_1100, 1'b0);
        chk("to_release", 32'(grant), 32'h0);
        chk("to_busy", 32'(busy), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0; byt[i] = 8'h00; lst[i] = 1'b0;
        end
        for (int n = 0; n < 4000; n++) begin
            logic [3:0]  q;
            logic [3:0]  l;
            logic [31:0] d;
            for (int i = 0; i < 4; i++) begin
                if (!act[i] && $urandom_range(3) == 0) begin
                    act[i] = 1'b1;
                    byt[i] = 8'($urandom);
                    lst[i] = ($urandom_range(2) == 0);
                end else if (act[i] && $urandom_range(47) == 0) begin
                    act[i] = 1'b0;
                end
                q[i] = act[i];
                l[i] = act[i] ? lst[i] : 1'($urandom);
                d[8*i +: 8] = act[i] ? byt[i] : 8'($urandom);
            end
            cyc(($urandom_range(299) == 0), q, l, d, ($urandom_range(2) == 0));
            for (int i = 0; i < 4; i++)
                if (m_ack[i]) act[i] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles of owner req-low before a held lock is released; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-port byte request; port i holds req[i], data and last stable until ack[i].
REQ-005 data  input  32  packed bytes, port i on data[8*i+7:8*i].
REQ-006 last  input  4  per-port end-of-message flag, qualified with req[i].
REQ-007 ack  output  4  one-cycle pulse: port's current byte accepted by the transmitter.
REQ-008 grant  output  4  one-hot current owner; all-zero when unowned.
REQ-009 tx_req  output  1  to uart_tx tx_req.
REQ-010 tx_ready  input  1  from uart_tx tx_ready: one-cycle byte-accepted pulse.
REQ-011 tx_data  output  8  to uart_tx tx_data.
REQ-012 busy  output  1  high whenever grant is non-zero.

Function
REQ-013 Two states: IDLE (no owner) and LOCK (one owner); grant, owner index, rr pointer, timeout counter held in registers.
REQ-014 IDLE: if req non-zero, select the first set bit scanning from pointer upward with wrap (pointer, pointer+1 mod 4, ...); next cycle grant = that one-hot bit, state LOCK.
REQ-015 IDLE with req all-zero: remain IDLE, grant 0.
REQ-016 Arbitration latency: req rising in IDLE -> grant asserted exactly one cycle later -> tx_req asserted same cycle as grant.
REQ-017 tx_req = LOCK and req[owner]; tx_data = data byte of owner; both combinational from registered owner, tx_data 0 when IDLE.
REQ-018 ack[owner] = tx_req and tx_ready, same cycle as tx_ready; other ack bits 0.
REQ-019 tx_ready while IDLE, or while req[owner]=0: ignored, no ack, no state change.
REQ-020 On an accepted byte with last[owner]=1: next cycle state IDLE, grant 0, pointer = owner+1 mod 4.
REQ-021 On an accepted byte with last[owner]=0: remain LOCK on same owner; requests from other ports do not preempt.
REQ-022 Timeout counter: cleared on entry to LOCK and whenever req[owner]=1; increments each LOCK cycle with req[owner]=0, saturating.
REQ-023 Counter reaching TIMEOUT-1 with req[owner] still 0: next cycle IDLE, grant 0, pointer = owner+1 mod 4; no ack issued.
REQ-024 Pointer advances only on release (REQ-020, REQ-023); a port re-requesting immediately after release loses to any other pending port.
REQ-025 Re-arbitration after release takes one IDLE cycle; no back-to-back grant change within one cycle.
REQ-026 Correctness requires uart_tx BAUD_DIVIDE >= 2, so tx_ready is never followed by a second sample of the same byte.

Reset
REQ-027 reset high at a clock edge: state IDLE, grant 0, owner 0, pointer 0, counter 0; hence tx_req 0, ack 0, busy 0, tx_data 0 the following cycle.
REQ-028 reset mid-message drops the lock without ack; a byte already accepted by uart_tx completes on the line independently.
REQ-029 First arbitration after reset gives priority to port 0.

Verification
REQ-030 Single port 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> grant=0100 one cycle after req, three ack[2] pulses aligned to tx_ready, tx_data matches each byte, IDLE after third ack.
REQ-031 req=1111 continuously, each message one byte -> grant sequence 0001,0010,0100,1000,0001, one IDLE cycle between grants.
REQ-032 Port 0 mid-message (last=0), port 3 requesting -> port 0 keeps grant for all bytes until last=1; port 3 granted next, not port 0 again.
REQ-033 Port 1 owns, drops req for TIMEOUT cycles (TIMEOUT=8) -> grant 0 after exactly 8 low cycles, no ack; port 1 re-asserting at cycle 5 clears counter and keeps lock.
REQ-034 tx_ready pulsed while IDLE and while owner req low -> ack stays 0000, state unchanged.
REQ-035 reset asserted during LOCK with tx_req high -> next cycle grant 0000, tx_req 0, busy 0; next req=0100 granted port 2 under pointer 0 scan.
